ahb_uvc_mem_slave: RTL and testbench
====================================

// Module: ahb_uvc_mem_slave
// PURPOSE
//  AHB-Lite responder: memory-backed slave sitting on the opposite end of the AHB
//  interface from the UVC master agent. Decodes address phase, inserts programmable
//  wait states, services byte/half/word reads and writes, and returns the
//  two-cycle ERROR response. Used as the DUT/reference target for master-agent tests.
// PARAMETERS
//  ADDR_WIDTH   32   haddr width
//  DATA_WIDTH   32   hwdata/hrdata width (fixed 32; word = 4 bytes)
//  MEM_DEPTH    256  number of 32-bit words; valid byte range 0 .. MEM_DEPTH*4-1
//  WAIT_STATES  0    hreadyout-low cycles inserted in every OKAY data phase (0..15)
// PORTS
//  hclk       in   1           bus clock, all logic on rising edge
//  hresetn    in   1           asynchronous active-low reset
//  hsel       in   1           slave select
//  haddr      in   ADDR_WIDTH  transfer address
//  htrans     in   2           IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//  hwrite     in   1           1=write 0=read
//  hsize      in   3           0=byte 1=half 2=word, >2 illegal
//  hburst     in   3           burst type, not used for decode (addresses taken as given)
//  hprot      in   4           ignored
//  hmastlock  in   1           ignored
//  hwdata     in   DATA_WIDTH  write data, valid in data phase
//  hready     in   1           bus-level ready (previous transfer complete)
//  hreadyout  out  1           slave ready for this data phase
//  hresp      out  1           0=OKAY 1=ERROR
//  hrdata     out  DATA_WIDTH  read data
// BEHAVIOUR
//  Reset (async assert, sync deassert timing not required): state=IDLE, hreadyout=1,
//   hresp=0, hrdata=0, wait counter=0, pending write discarded. Memory not reset.
//  Accept: address phase captured (haddr,hwrite,hsize regs) at edge where
//   hsel & hready & htrans[1]. IDLE/BUSY or hsel=0 -> no access, zero-wait OKAY.
//  Error check at accept: haddr >= MEM_DEPTH*4, or hsize>2, or misaligned
//   (half: haddr[0]!=0; word: haddr[1:0]!=0).
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//   IDLE: hreadyout=1,hresp=0. Accept legal & WAIT_STATES>0 -> WAIT (cnt=WAIT_STATES);
//    accept legal & WAIT_STATES=0 -> data phase completes next cycle (stay IDLE,
//    dphase flag set); accept illegal -> ERR1.
//   WAIT: hreadyout=0; cnt decrements each cycle; at cnt==1 -> IDLE with dphase set,
//    so hreadyout=1 completes transfer. Total latency = WAIT_STATES+1 cycles.
//   ERR1: hreadyout=0,hresp=1 -> ERR2 unconditionally.
//   ERR2: hreadyout=1,hresp=1; new address phase may be accepted this cycle
//    (evaluated as from IDLE); else -> IDLE.
//  Write: memory updated at the edge ending a completing OKAY data phase
//   (hreadyout=1, dphase, write). Byte lanes from addr_q[1:0]/size_q, little endian:
//   byte -> lane addr_q[1:0]; half -> lanes {addr_q[1],0}+1..0; word -> all 4.
//   Erroring transfers never write.
//  Read: hrdata = mem[addr_q>>2] (full word, all lanes) during completing read data
//   phase; 0 otherwise. Back-to-back write then read same address returns new data.
//  Address phase during WAIT/ERR1 (hready=0) is ignored; master must hold it.
//  Reset mid-WAIT: FSM to IDLE, write dropped, outputs to reset values immediately.
// TESTING
//  WAIT_STATES=0: write word 0xDEADBEEF @0x10, read @0x10 -> hrdata=0xDEADBEEF, hreadyout never low.
//  WAIT_STATES=3: read @0x10 -> hreadyout low exactly 3 cycles, data on 4th, hresp=0.
//  Byte writes 0xAA@0x21, 0xBB@0x22 after word 0 @0x20 -> word read @0x20 = 0x00BBAA00.
//  Write @MEM_DEPTH*4 -> ERR1 (hreadyout=0,hresp=1), ERR2 (1,1); memory unchanged; misaligned word @0x2 same.
//  Pipelined NONSEQ/SEQ burst of 4 words @0x40..0x4C, WAIT_STATES=0 -> 4 completing cycles, readback matches.
//  hresetn low during WAIT of a write -> hreadyout=1,hresp=0 at once; later read shows old data.

Source files
------------

// File: rtl/ahb_uvc_mem_slave.sv
// AHB-Lite memory-backed responder: byte/half/word access, WAIT_STATES+1 cycle OKAY data phase.
// Two-cycle ERROR for out-of-range, illegal-size or misaligned transfers; address phases seen while hready=0 are ignored.
module ahb_uvc_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int AQW  = IDXW + 2;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic            dphase, dphase_d;
  logic            accept, acc_err, capture;
  logic [AQW-1:0]  addr_q;
  logic            write_q;
  logic [1:0]      size_q;
  logic [IDXW-1:0] widx;
  logic [3:0]      be;
  logic            complete;
  logic            unused_inputs;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

  assign accept  = hsel & hready & htrans[1];
  assign acc_err = ({1'b0, haddr} >= MEM_BYTES) || (hsize > 3'd2) ||
                   ((hsize == 3'd1) && haddr[0]) ||
                   ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  // A legal transfer's data phase finishes in the first IDLE cycle with dphase set.
  assign complete = (state == ST_IDLE) && dphase;
  assign widx     = addr_q[AQW-1:2];
  assign hrdata   = (complete && !write_q) ? mem[widx] : '0;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    dphase_d  = 1'b0;
    capture   = 1'b0;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: begin
        hresp   = (state == ST_ERR2);
        state_d = ST_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else if (WS == 4'd0) begin
            capture  = 1'b1;
            dphase_d = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        cnt_d     = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_d  = ST_IDLE;
          dphase_d = 1'b1;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      dphase  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      dphase <= dphase_d;
      if (capture) begin
        addr_q  <= haddr[AQW-1:0];
        write_q <= hwrite;
        size_q  <= hsize[1:0];
      end
    end
  end

  // Little-endian lane selection from the captured address and size.
  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be[addr_q[1:0]] = 1'b1;
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (complete && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_uvc_mem_slave.sv
// Bench for ahb_uvc_mem_slave: two instances (0 and 3 wait states), pipelined master driver,
// byte-array reference memory and a queue-based scoreboard checked by an independent bus monitor.
`timescale 1ns/1ps
module tb_ahb_uvc_mem_slave;

  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  typedef struct {
    logic        err;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  logic        hclk;
  logic        hresetn_a   [2];
  logic        hsel_a      [2];
  logic [31:0] haddr_a     [2];
  logic [1:0]  htrans_a    [2];
  logic        hwrite_a    [2];
  logic [2:0]  hsize_a     [2];
  logic [2:0]  hburst_a    [2];
  logic [3:0]  hprot_a     [2];
  logic        hmastlock_a [2];
  logic [31:0] hwdata_a    [2];
  logic        hready_a    [2];
  logic        hreadyout_a [2];
  logic        hresp_a     [2];
  logic [31:0] hrdata_a    [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq [2][$];
  logic [7:0] mmem  [2][NBYTES];
  bit         known [2][NBYTES];
  bit   pend   [2];
  int   lowcnt [2];
  bit   saw1   [2];

  assign hready_a[0] = hreadyout_a[0];
  assign hready_a[1] = hreadyout_a[1];

  ahb_uvc_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn_a[0]), .hsel(hsel_a[0]), .haddr(haddr_a[0]),
    .htrans(htrans_a[0]), .hwrite(hwrite_a[0]), .hsize(hsize_a[0]), .hburst(hburst_a[0]),
    .hprot(hprot_a[0]), .hmastlock(hmastlock_a[0]), .hwdata(hwdata_a[0]), .hready(hready_a[0]),
    .hreadyout(hreadyout_a[0]), .hresp(hresp_a[0]), .hrdata(hrdata_a[0]));

  ahb_uvc_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hresetn(hresetn_a[1]), .hsel(hsel_a[1]), .haddr(haddr_a[1]),
    .htrans(htrans_a[1]), .hwrite(hwrite_a[1]), .hsize(hsize_a[1]), .hburst(hburst_a[1]),
    .hprot(hprot_a[1]), .hmastlock(hmastlock_a[1]), .hwdata(hwdata_a[1]), .hready(hready_a[1]),
    .hreadyout(hreadyout_a[1]), .hresp(hresp_a[1]), .hrdata(hrdata_a[1]));

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: illegal if beyond memory, size above word, or not naturally aligned.
  function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size);
    if (addr >= NBYTES) return 1'b1;
    if (size > 3'd2) return 1'b1;
    return (addr % (1 << size)) != 0;
  endfunction

  task automatic bus_xfer(input int d, input logic [31:0] addr, input logic wr,
                          input logic [2:0] size, input logic [31:0] wdata, input logic [1:0] tr);
    exp_t e;
    bit   acc;
    int   k;
    int   a;
    hsel_a[d] = 1'b1; haddr_a[d] = addr; htrans_a[d] = tr; hwrite_a[d] = wr; hsize_a[d] = size;
    hburst_a[d] = 3'($urandom); hprot_a[d] = 4'($urandom); hmastlock_a[d] = 1'($urandom);
    acc = 1'b0;
    k = 0;
    while (!acc && k < 64) begin
      @(negedge hclk);
      acc = hready_a[d];
      @(posedge hclk);
      #1;
      k++;
    end
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL accept_timeout_dut%0d: hready stayed 0, expected 1", d);
    end else begin
      e.err  = is_err(addr, size);
      e.data = 32'h0;
      e.mask = 32'hFFFF_FFFF;
      if (!e.err && wr) begin
        for (int i = 0; i < (1 << size); i++) begin
          a = int'(addr) + i;
          mmem[d][a]  = wdata[8*(a%4) +: 8];
          known[d][a] = 1'b1;
        end
      end else if (!e.err) begin
        for (int b = 0; b < 4; b++) begin
          a = (int'(addr) & ~3) + b;
          e.data[8*b +: 8] = mmem[d][a];
          e.mask[8*b +: 8] = known[d][a] ? 8'hFF : 8'h00;
        end
      end
      sbq[d].push_back(e);
      hwdata_a[d] = wdata;
    end
  endtask

  task automatic idle(input int d, input int n, input logic sel, input logic [1:0] tr);
    hsel_a[d] = sel; htrans_a[d] = tr; haddr_a[d] = $urandom; hwrite_a[d] = 1'($urandom);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Bus monitor: tracks data phases from observed address phases and checks each completion.
  always @(negedge hclk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!hresetn_a[d]) begin
        pend[d] = 1'b0;
      end else if (pend[d]) begin
        if (!hreadyout_a[d]) begin
          lowcnt[d]++;
          if (hresp_a[d]) saw1[d] = 1'b1;
        end else begin
          n_cmp++;
          if (sbq[d].size() == 0) begin
            n_bad++;
            $display("FAIL sb_underflow_dut%0d: completion with no expected entry", d);
          end else begin
            e = sbq[d].pop_front();
            chk($sformatf("hresp_dut%0d", d), 32'(hresp_a[d]), 32'(e.err));
            chk($sformatf("wait_cycles_dut%0d", d), 32'(lowcnt[d]), e.err ? 32'd1 : 32'(ws_of(d)));
            chk($sformatf("err_first_cycle_dut%0d", d), 32'(saw1[d]), 32'(e.err));
            chk($sformatf("hrdata_dut%0d", d), hrdata_a[d] & e.mask, e.data & e.mask);
          end
          pend[d] = 1'b0;
        end
      end else begin
        chk($sformatf("idle_ready_resp_dut%0d", d), {30'd0, hreadyout_a[d], hresp_a[d]}, 32'd2);
        chk($sformatf("idle_hrdata_dut%0d", d), hrdata_a[d], 32'd0);
      end
      if (hresetn_a[d] && hsel_a[d] && hready_a[d] && htrans_a[d][1]) begin
        pend[d]   = 1'b1;
        lowcnt[d] = 0;
        saw1[d]   = 1'b0;
      end
    end
  end

  task automatic directed(input int d);
    bus_xfer(d, 32'h00, 1'b1, 3'd2, 32'h1111_1111, 2'd2);
    bus_xfer(d, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, 2'd2);
    bus_xfer(d, 32'h10, 1'b0, 3'd2, 32'h0, 2'd2);
    bus_xfer(d, 32'h20, 1'b1, 3'd2, 32'h0, 2'd2);
    bus_xfer(d, 32'h21, 1'b1, 3'd0, 32'h0000_AA00, 2'd2);
    bus_xfer(d, 32'h22, 1'b1, 3'd0, 32'h00BB_0000, 2'd2);
    bus_xfer(d, 32'h20, 1'b0, 3'd2, 32'h0, 2'd2);
    idle(d, 2, 1'b1, 2'd0);
    bus_xfer(d, NBYTES, 1'b1, 3'd2, 32'hBADB_AD00, 2'd2);
    bus_xfer(d, 32'h02, 1'b1, 3'd2, 32'hCAFE_F00D, 2'd2);
    bus_xfer(d, 32'h00, 1'b0, 3'd2, 32'h0, 2'd2);
    bus_xfer(d, 32'h10, 1'b0, 3'd2, 32'h0, 2'd2);
    for (int i = 0; i < 4; i++)
      bus_xfer(d, 32'h40 + 32'(4*i), 1'b1, 3'd2, $urandom, (i == 0) ? 2'd2 : 2'd3);
    for (int i = 0; i < 4; i++)
      bus_xfer(d, 32'h40 + 32'(4*i), 1'b0, 3'd2, 32'h0, (i == 0) ? 2'd2 : 2'd3);
    bus_xfer(d, 32'h13, 1'b1, 3'd1, 32'h5555_5555, 2'd2);
    bus_xfer(d, 32'h12, 1'b1, 3'd1, 32'h7788_0000, 2'd2);
    bus_xfer(d, 32'h10, 1'b0, 3'd2, 32'h0, 2'd2);
    idle(d, 6, 1'b0, 2'd0);
  endtask

  task automatic rand_traffic(input int d, input int n);
    logic [31:0] addr;
    logic [2:0]  size;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0)
        idle(d, $urandom_range(1, 3), 1'($urandom), 2'($urandom_range(0, 1)));
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       addr = NBYTES + $urandom_range(0, 63);
        1:       addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: addr = $urandom_range(0, NBYTES - 1);
      endcase
      if ($urandom_range(0, 4) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
      bus_xfer(d, addr, 1'($urandom), size, $urandom, 2'($urandom_range(2, 3)));
    end
    idle(d, 8, 1'b0, 2'd0);
    chk($sformatf("drain_dut%0d", d), 32'(sbq[d].size()), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      hresetn_a[d] = 1'b0; hsel_a[d] = 1'b0; haddr_a[d] = 32'h0; htrans_a[d] = 2'd0;
      hwrite_a[d] = 1'b0; hsize_a[d] = 3'd0; hburst_a[d] = 3'd0; hprot_a[d] = 4'd0;
      hmastlock_a[d] = 1'b0; hwdata_a[d] = 32'h0; pend[d] = 1'b0; lowcnt[d] = 0; saw1[d] = 1'b0;
    end
    repeat (3) @(posedge hclk);
    #1;
    hresetn_a[0] = 1'b1;
    hresetn_a[1] = 1'b1;
    idle(0, 2, 1'b0, 2'd0);

    directed(0);
    directed(1);

    // Write to 0x10 on the wait-state slave, then reset it mid-WAIT: the write must be lost.
    hsel_a[1] = 1'b1; haddr_a[1] = 32'h10; htrans_a[1] = 2'd2; hwrite_a[1] = 1'b1; hsize_a[1] = 3'd2;
    @(posedge hclk);
    #1;
    htrans_a[1] = 2'd0;
    hwdata_a[1] = 32'h1234_5678;
    @(posedge hclk);
    #1;
    chk("wait_before_reset", 32'(hreadyout_a[1]), 32'd0);
    hresetn_a[1] = 1'b0;
    #1;
    chk("rst_hreadyout", 32'(hreadyout_a[1]), 32'd1);
    chk("rst_hresp", 32'(hresp_a[1]), 32'd0);
    chk("rst_hrdata", hrdata_a[1], 32'd0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn_a[1] = 1'b1;
    idle(1, 1, 1'b0, 2'd0);
    bus_xfer(1, 32'h10, 1'b0, 3'd2, 32'h0, 2'd2);
    idle(1, 6, 1'b0, 2'd0);

    rand_traffic(0, 300);
    rand_traffic(1, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
